// File: rtl/port_bank_pkg.sv
// Shared types and helpers for the port_bank channel array.
package port_bank_pkg;

  // Per-channel direction state. Exposed on the bus as dbg_state.
  typedef enum logic [1:0] {
    ST_RX       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_e;

  // Turnaround counter width; never narrower than one bit so that the
  // TURN_CYCLES=0 build still has a legal (unused) counter.
  function automatic int cnt_width(input int turn_cycles);
    return (turn_cycles < 1) ? 1 : $clog2(turn_cycles + 1);
  endfunction

endpackage

// File: rtl/port_bank_if.sv
// Core-side bundle of the port bank. There is no valid/ready pair here:
// dir_req is a level request held by the core for as long as it wants that
// direction, and every output is a registered level (din_chg is a single
// cycle pulse). The master side is the core logic, the slave is port_bank.
interface port_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 2
);
  import port_bank_pkg::*;

  logic [CHANNELS-1:0]       dir_req;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       din_chg;
  logic [CHANNELS-1:0]       oe;
  logic [CHANNELS-1:0]       busy;
  state_e [CHANNELS-1:0]     dbg_state;

  modport master (output dir_req, dout, input din, din_chg, oe, busy, dbg_state);
  modport slave  (input dir_req, dout, output din, din_chg, oe, busy, dbg_state);
endinterface

// File: rtl/port_bank_chan.sv
// One bidirectional channel: direction FSM with turnaround gap, registered
// output data, tristate pin driver, input synchroniser and change detect.
module port_bank_chan
  import port_bank_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] dout,
  inout  wire  [WIDTH-1:0] io,
  output logic [WIDTH-1:0] din,
  output logic             din_chg,
  output logic             oe,
  output logic             busy,
  output state_e           state_o
);

  localparam int CW   = cnt_width(TURN_CYCLES);
  localparam int LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  state_e                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic                                  oe_q, oe_d;
  logic                                  busy_q, busy_d;
  logic [WIDTH-1:0]                      dout_q, dout_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]     sync_q, sync_d;
  logic [WIDTH-1:0]                      prev_q, prev_d;
  logic                                  chg;

  // Direction FSM: a drive request must pass through TURN_OUT (abortable),
  // a release always runs the full TURN_IN gap before RX is re-entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RX: begin
        if (dir_req) begin
          if (TURN_CYCLES == 0) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_TURN_OUT;
            cnt_d   = '0;
          end
        end
      end
      ST_TURN_OUT: begin
        if (!dir_req)             state_d = ST_RX;
        else if (cnt_q == LAST_C) state_d = ST_DRIVE;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      ST_DRIVE: begin
        if (!dir_req) begin
          if (TURN_CYCLES == 0) begin
            state_d = ST_RX;
          end else begin
            state_d = ST_TURN_IN;
            cnt_d   = '0;
          end
        end
      end
      ST_TURN_IN: begin
        if (cnt_q == LAST_C) state_d = ST_RX;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_RX;
    endcase
  end

  // Output flags and data/synchroniser next values; flags decode next state.
  always_comb begin
    oe_d      = (state_d == ST_DRIVE);
    busy_d    = (state_d == ST_TURN_OUT) || (state_d == ST_TURN_IN);
    dout_d    = dout;
    sync_d    = sync_q;
    sync_d[0] = io;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d    = sync_q[SYNC_STAGES-1];
  end

  // Change detect; an unknown compare (X pin) falls to the else branch.
  always_comb begin
    chg = 1'b0;
    if (sync_q[SYNC_STAGES-1] != prev_q) chg = 1'b1;
  end

  // All channel state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
    end
  end

  assign io      = oe_q ? dout_q : {WIDTH{1'bz}};
  assign din     = sync_q[SYNC_STAGES-1];
  assign din_chg = chg;
  assign oe      = oe_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: rtl/port_bank.sv
// Array of CHANNELS independent bidirectional ports between core and pins.
module port_bank
  import port_bank_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int CHANNELS    = 2,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  port_bank_if.slave                bus,
  inout  wire [CHANNELS*WIDTH-1:0]  io
);

  // One channel per slice; no shared state or arbitration between them.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    port_bank_chan #(
      .WIDTH       (WIDTH),
      .TURN_CYCLES (TURN_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .dir_req (bus.dir_req[c]),
      .dout    (bus.dout[c*WIDTH +: WIDTH]),
      .io      (io[c*WIDTH +: WIDTH]),
      .din     (bus.din[c*WIDTH +: WIDTH]),
      .din_chg (bus.din_chg[c]),
      .oe      (bus.oe[c]),
      .busy    (bus.busy[c]),
      .state_o (bus.dbg_state[c])
    );
  end

endmodule

// File: tb/tb_port_bank.sv
// Bench for port_bank: three builds (TURN_CYCLES 1, 3, 0) on one clock.
module tb_port_bank;
  import port_bank_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  port_bank_if #(.CHANNELS(2), .WIDTH(2)) bus_a ();
  port_bank_if #(.CHANNELS(1), .WIDTH(2)) bus_b ();
  port_bank_if #(.CHANNELS(1), .WIDTH(2)) bus_c ();
  wire [3:0] io_a;
  wire [1:0] io_b;
  wire [1:0] io_c;

  logic       drv_en  = 1'b1;
  logic [1:0] drv_val = 2'b00;
  assign io_a[3:2] = drv_en ? drv_val : 2'bzz;

  port_bank #(.WIDTH(2), .CHANNELS(2), .TURN_CYCLES(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .io(io_a));
  port_bank #(.WIDTH(2), .CHANNELS(1), .TURN_CYCLES(3), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .io(io_b));
  port_bank #(.WIDTH(2), .CHANNELS(1), .TURN_CYCLES(0), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .io(io_c));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard (channel 1 receive path) ----------------
  logic [1:0] exp_q[$];
  logic [1:0] last_rx = 2'b00;

  always @(negedge clk) begin
    if (!rst && bus_a.din_chg[1] === 1'b1) begin
      check("rx_pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_din", 32'(bus_a.din[3:2]), 32'(exp_q.pop_front()));
    end
  end

  logic c_busy_seen = 1'b0;
  always @(negedge clk) if (bus_c.busy[0] === 1'b1) c_busy_seen <= 1'b1;

  // Drive a new pin value on channel 1 and wait (bounded) for it to be seen.
  task automatic rx_send(input logic [1:0] v);
    exp_q.push_back(v);
    drv_val = v;
    last_rx = v;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    check("rx_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] v;
    bus_a.dir_req = 2'b11;  bus_a.dout = 4'b1111;
    bus_b.dir_req = 1'b0;   bus_b.dout = 2'b01;
    bus_c.dir_req = 1'b0;   bus_c.dout = 2'b11;

    // Reset held two edges with requests active.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_oe",    32'(bus_a.oe),      32'd0);
      check("rst_busy",  32'(bus_a.busy),    32'd0);
      check("rst_din",   32'(bus_a.din),     32'd0);
      check("rst_chg",   32'(bus_a.din_chg), 32'd0);
      check("rst_state", 32'(bus_a.dbg_state[0]), 32'(ST_RX));
    end

    // Drive path: channel 0 out, channel 1 stays receive.
    rst = 1'b0; bus_a.dir_req = 2'b01; bus_a.dout = 4'b0010;
    tick();
    check("drv_busy1", 32'(bus_a.busy), 32'b01);
    check("drv_oe1",   32'(bus_a.oe),   32'b00);
    tick();
    check("drv_oe2",   32'(bus_a.oe),   32'b01);
    check("drv_busy2", 32'(bus_a.busy), 32'b00);
    check("drv_pin",   32'(io_a[1:0]),  32'b10);
    check("drv_state", 32'(bus_a.dbg_state[0]), 32'(ST_DRIVE));
    tick(); tick();
    check("loopback_din", 32'(bus_a.din[1:0]), 32'b10);
    bus_a.dout = 4'b0001;
    tick();
    check("drv_latency", 32'(io_a[1:0]), 32'b01);
    check("ch1_oe_off",  32'(bus_a.oe[1]), 32'd0);

    // Receive path: directed latency check, then random values.
    exp_q.push_back(2'b11);
    drv_val = 2'b11; last_rx = 2'b11;
    tick();
    check("rx_lat1_din", 32'(bus_a.din[3:2]), 32'b00);
    tick();
    check("rx_lat2_din", 32'(bus_a.din[3:2]), 32'b11);
    check("rx_lat2_chg", 32'(bus_a.din_chg[1]), 32'd1);
    tick();
    check("rx_chg_once", 32'(bus_a.din_chg[1]), 32'd0);
    for (int n = 0; n < 6; n++) begin
      v = 2'($urandom_range(0, 3));
      if (v == last_rx) v = v + 2'd1;
      rx_send(v);
    end
    drv_val = last_rx;           // unchanged pin: no pulse may appear
    for (int i = 0; i < 4; i++) tick();
    if (last_rx != 2'b00) rx_send(2'b00);

    // Reset while channel 0 drives.
    rst = 1'b1;
    tick();
    check("mid_rst_oe",    32'(bus_a.oe),      32'd0);
    check("mid_rst_busy",  32'(bus_a.busy),    32'd0);
    check("mid_rst_din",   32'(bus_a.din),     32'd0);
    check("mid_rst_state", 32'(bus_a.dbg_state[0]), 32'(ST_RX));
    rst = 1'b0;
    tick();
    check("post_rst_turn", 32'(bus_a.dbg_state[0]), 32'(ST_TURN_OUT));
    tick();
    check("post_rst_oe",   32'(bus_a.oe), 32'b01);

    // TURN_CYCLES=3: abort during TURN_OUT.
    bus_b.dir_req = 1'b1;
    tick(); check("b_abort_busy1", 32'(bus_b.busy), 32'd1);
    tick(); check("b_abort_oe2",   32'(bus_b.oe),   32'd0);
    bus_b.dir_req = 1'b0;
    tick();
    check("b_abort_state", 32'(bus_b.dbg_state[0]), 32'(ST_RX));
    check("b_abort_oe",    32'(bus_b.oe),   32'd0);
    check("b_abort_busy",  32'(bus_b.busy), 32'd0);
    tick();

    // TURN_CYCLES=3: full turn out, then forced full TURN_IN.
    bus_b.dir_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_out_busy", 32'(bus_b.busy), 32'd1);
      check("b_out_oe",   32'(bus_b.oe),   32'd0);
    end
    tick();
    check("b_drive_oe",   32'(bus_b.oe),   32'd1);
    check("b_drive_busy", 32'(bus_b.busy), 32'd0);
    bus_b.dir_req = 1'b0;
    tick();
    bus_b.dir_req = 1'b1;
    check("b_in_state0", 32'(bus_b.dbg_state[0]), 32'(ST_TURN_IN));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("b_in_state", 32'(bus_b.dbg_state[0]), 32'(ST_TURN_IN));
      check("b_in_oe",    32'(bus_b.oe), 32'd0);
    end
    tick();
    check("b_in_done_state", 32'(bus_b.dbg_state[0]), 32'(ST_RX));
    check("b_in_done_busy",  32'(bus_b.busy), 32'd0);
    tick();
    check("b_reeval_state",  32'(bus_b.dbg_state[0]), 32'(ST_TURN_OUT));
    check("b_reeval_oe",     32'(bus_b.oe), 32'd0);

    // TURN_CYCLES=0: direct switching.
    bus_c.dir_req = 1'b1;
    tick();
    check("c_oe_on",  32'(bus_c.oe), 32'd1);
    check("c_pin",    32'(io_c),     32'b11);
    bus_c.dir_req = 1'b0;
    tick();
    check("c_oe_off", 32'(bus_c.oe), 32'd0);
    tick();
    check("c_busy_never", 32'(c_busy_seen), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
